// File: rtl/synth_pkg.sv
// rtl/synth_pkg.sv - shared audio sample types and frame constants
package synth_pkg;

  localparam int SAMPLE_W    = 16;
  localparam int FRAME_SLOTS = 32;
  localparam int SLOT_W      = $clog2(FRAME_SLOTS);

  // Signed mono sample exchanged with the reverb stage
  typedef logic signed [SAMPLE_W-1:0] sample_t;

  function automatic logic slot_is_right(input logic [SLOT_W-1:0] slot);
    return slot >= SLOT_W'(FRAME_SLOTS / 2);
  endfunction

endpackage

// File: rtl/i2s_tx_if.sv
// rtl/i2s_tx_if.sv - sample FIFO push/pop bundle between i2s_tx and sample_fifo
interface i2s_tx_if #(
  parameter int DEPTH = 4
) ();

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                 push;
  logic                 pop;
  synth_pkg::sample_t   din;
  synth_pkg::sample_t   dout;
  logic                 full;
  logic                 empty;
  logic [CNT_W-1:0]     count;

  modport master (output push, pop, din, input dout, full, empty, count);
  modport slave  (input push, pop, din, output dout, full, empty, count);

endinterface

// File: rtl/sample_fifo.sv
// rtl/sample_fifo.sv - power-of-two sample FIFO with explicit occupancy count
module sample_fifo import synth_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  i2s_tx_if.slave   fifo
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  sample_t            mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               do_push, do_pop;

  // A push into a full FIFO is only taken when a pop frees a slot the same cycle
  assign do_pop  = fifo.pop && (count_q != '0);
  assign do_push = fifo.push && ((count_q != CNT_W'(DEPTH)) || do_pop);

  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= fifo.din;
  end

  assign fifo.dout  = mem_q[rd_ptr_q];
  assign fifo.full  = (count_q == CNT_W'(DEPTH));
  assign fifo.empty = (count_q == '0);
  assign fifo.count = count_q;

endmodule

// File: rtl/i2s_tx.sv
// rtl/i2s_tx.sv - mono-to-stereo I2S transmitter: bit clock divider, slot counter, shifter
module i2s_tx import synth_pkg::*; #(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic    clk_50m,
  input  logic    rst,
  input  logic    ready_in,
  input  sample_t signal_in,
  output logic    i2s_bclk,
  output logic    i2s_lrck,
  output logic    i2s_sdata,
  output logic    underrun,
  output logic    overflow
);

  localparam int SH_W = 2 * SAMPLE_W;

  logic [7:0]         div_q, div_d;
  logic               bclk_q, bclk_d;
  logic [SLOT_W-1:0]  slot_q, slot_d;
  logic               lrck_q, lrck_d;
  sample_t            cur_q, cur_d;
  logic [SH_W-1:0]    sh_q, sh_d;
  logic               underrun_q, underrun_d;
  logic               overflow_q, overflow_d;
  logic               wrap, fall_tick, frame_start;

  i2s_tx_if #(.DEPTH(FIFO_DEPTH)) fifo_bus ();

  sample_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk  (clk_50m),
    .rst  (rst),
    .fifo (fifo_bus)
  );

  assign wrap        = (div_q == 8'(CLK_DIV - 1));
  assign fall_tick   = wrap && bclk_q;
  // Slot counter resets to the last slot so the first fall tick starts a frame
  assign frame_start = fall_tick && (slot_q == SLOT_W'(FRAME_SLOTS - 1));

  // An empty FIFO never hands out the sample being pushed in the same cycle
  assign fifo_bus.push = ready_in;
  assign fifo_bus.pop  = frame_start && !fifo_bus.empty;
  assign fifo_bus.din  = signal_in;

  always_comb begin
    div_d      = wrap ? 8'd0 : div_q + 8'd1;
    bclk_d     = wrap ? ~bclk_q : bclk_q;
    slot_d     = slot_q;
    lrck_d     = lrck_q;
    cur_d      = cur_q;
    sh_d       = sh_q;
    if (fall_tick) begin
      slot_d = slot_q + 1'b1;
      lrck_d = slot_is_right(slot_d);
      if (fifo_bus.pop) cur_d = fifo_bus.dout;
      if (slot_q == '0) sh_d = {cur_q, cur_q};
      else              sh_d = {sh_q[SH_W-2:0], 1'b0};
    end
    underrun_d = frame_start && (fifo_bus.count == '0);
    overflow_d = ready_in && fifo_bus.full && !fifo_bus.pop;
  end

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      div_q      <= '0;
      bclk_q     <= 1'b0;
      slot_q     <= SLOT_W'(FRAME_SLOTS - 1);
      lrck_q     <= 1'b1;
      cur_q      <= '0;
      sh_q       <= '0;
      underrun_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      div_q      <= div_d;
      bclk_q     <= bclk_d;
      slot_q     <= slot_d;
      lrck_q     <= lrck_d;
      cur_q      <= cur_d;
      sh_q       <= sh_d;
      underrun_q <= underrun_d;
      overflow_q <= overflow_d;
    end
  end

  assign i2s_bclk  = bclk_q;
  assign i2s_lrck  = lrck_q;
  assign i2s_sdata = sh_q[SH_W-1];
  assign underrun  = underrun_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_i2s_tx.sv
// tb/tb_i2s_tx.sv - scoreboard bench for i2s_tx: decoded frames checked against queued samples
module tb_i2s_tx;
  import synth_pkg::*;

  localparam int D     = 4;
  localparam int DEPTH = 4;

  logic    clk_50m = 1'b0;
  logic    rst;
  logic    ready_in;
  sample_t signal_in;
  logic    i2s_bclk, i2s_lrck, i2s_sdata, underrun, overflow;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc;
  int und_cnt, ovf_cnt;
  bit sdata_seen;
  logic [15:0] exp_q [$];

  always #5 clk_50m = ~clk_50m;

  i2s_tx #(.CLK_DIV(D), .FIFO_DEPTH(DEPTH)) dut (
    .clk_50m   (clk_50m),
    .rst       (rst),
    .ready_in  (ready_in),
    .signal_in (signal_in),
    .i2s_bclk  (i2s_bclk),
    .i2s_lrck  (i2s_lrck),
    .i2s_sdata (i2s_sdata),
    .underrun  (underrun),
    .overflow  (overflow)
  );

  i2s_tx_if #(.DEPTH(DEPTH)) f_bus ();
  sample_fifo #(.DEPTH(DEPTH)) u_fifo (.clk(clk_50m), .rst(rst), .fifo(f_bus));

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  always @(posedge clk_50m or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Monitor: decodes I2S on rising bclk, pops expected samples per completed frame
  initial begin
    logic [15:0] e;
    logic [31:0] word;
    bit bclk_prev, prev_lrck;
    int frames_seen, slot;
    forever begin
      @(negedge clk_50m);
      if (rst) begin
        und_cnt = 0; ovf_cnt = 0; sdata_seen = 0;
        bclk_prev = 0; prev_lrck = 1; frames_seen = 0; slot = 0; word = '0;
      end else begin
        if (underrun)  und_cnt++;
        if (overflow)  ovf_cnt++;
        if (i2s_sdata) sdata_seen = 1;
        if (i2s_bclk && !bclk_prev) begin
          word = {word[30:0], i2s_sdata};
          if (prev_lrck && !i2s_lrck) begin
            if (frames_seen > 0 && exp_q.size() > 0) begin
              e = exp_q.pop_front();
              chk("frame_word", 64'(word), 64'({e, e}));
            end
            frames_seen++;
            slot = 0;
          end else begin
            slot++;
            if (!prev_lrck && i2s_lrck && frames_seen > 0)
              chk("lrck_rise_slot", 64'(slot), 64'd16);
          end
          prev_lrck = i2s_lrck;
        end
        bclk_prev = i2s_bclk;
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    ready_in = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge clk_50m);
    rst = 1'b0;
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) @(negedge clk_50m);
  endtask

  task automatic push_at(input int n, input logic [15:0] v);
    while (cyc < n - 1) @(negedge clk_50m);
    ready_in  = 1'b1;
    signal_in = v;
    @(negedge clk_50m);
    ready_in  = 1'b0;
  endtask

  task automatic finish_test(input string name, input int end_cyc);
    wait_until(end_cyc);
    chk({name, "_frames_left"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] vals [5];
    rst = 1'b0; ready_in = 1'b0; signal_in = '0;
    f_bus.push = 1'b0; f_bus.pop = 1'b0; f_bus.din = '0;
    #2 rst = 1'b1;
    repeat (2) @(negedge clk_50m);
    chk("rst_bclk", 64'(i2s_bclk), 64'd0);
    chk("rst_lrck", 64'(i2s_lrck), 64'd1);
    chk("rst_sdata", 64'(i2s_sdata), 64'd0);
    chk("rst_underrun", 64'(underrun), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);

    // No input: three silent frames, one underrun each
    do_reset();
    repeat (3) exp_q.push_back(16'h0000);
    wait_until(700);
    chk("idle_underruns", 64'(und_cnt), 64'd3);
    finish_test("idle", 800);
    chk("idle_sdata_quiet", 64'(sdata_seen), 64'd0);

    // Single sample repeats while the FIFO runs dry
    do_reset();
    exp_q.push_back(16'h8001); exp_q.push_back(16'h8001);
    push_at(1, 16'h8001);
    finish_test("single", 600);
    chk("single_underruns", 64'(und_cnt), 64'd2);

    // Six back-to-back pushes: four kept, two dropped
    do_reset();
    for (int i = 1; i <= 4; i++) exp_q.push_back(16'(16'h1000 + i));
    for (int i = 1; i <= 6; i++) push_at(i, 16'(16'h1000 + i));
    finish_test("ovf", 1100);
    chk("ovf_overflows", 64'(ovf_cnt), 64'd2);
    chk("ovf_underruns", 64'(und_cnt), 64'd1);

    // Push lands on the same edge as a pop with the FIFO full
    do_reset();
    exp_q.push_back(16'h0A0A); exp_q.push_back(16'hB00B); exp_q.push_back(16'hC0C0);
    exp_q.push_back(16'hD00D); exp_q.push_back(16'hF00F); exp_q.push_back(16'h1234);
    push_at(1, 16'h0A0A); push_at(2, 16'hB00B); push_at(3, 16'hC0C0);
    push_at(4, 16'hD00D); push_at(5, 16'hEEEE); push_at(9, 16'hF00F);
    push_at(264, 16'h1234); push_at(265, 16'h4321);
    finish_test("fullpop", 1700);
    chk("fullpop_overflows", 64'(ovf_cnt), 64'd2);
    chk("fullpop_underruns", 64'(und_cnt), 64'd1);

    // Push lands on the same edge as a pop with the FIFO empty
    do_reset();
    exp_q.push_back(16'h0000); exp_q.push_back(16'hA5C3);
    push_at(8, 16'hA5C3);
    finish_test("emptypop", 580);
    chk("emptypop_underruns", 64'(und_cnt), 64'd2);
    chk("emptypop_overflows", 64'(ovf_cnt), 64'd0);

    // Steady stream, one sample per frame, signed extremes
    do_reset();
    vals = '{16'h7FFF, 16'h8000, 16'hFFFF, 16'h0001, 16'h5A5A};
    foreach (vals[k]) exp_q.push_back(vals[k]);
    foreach (vals[k]) push_at(3 + 256 * k, vals[k]);
    wait_until(1280);
    chk("stream_underruns", 64'(und_cnt), 64'd0);
    chk("stream_overflows", 64'(ovf_cnt), 64'd0);
    finish_test("stream", 1348);

    // Reset in slot 20 with three samples buffered
    do_reset();
    for (int i = 1; i <= 4; i++) push_at(i, 16'hFFFF);
    wait_until(174);
    #1 rst = 1'b1;
    #1;
    chk("midrst_bclk", 64'(i2s_bclk), 64'd0);
    chk("midrst_lrck", 64'(i2s_lrck), 64'd1);
    chk("midrst_sdata", 64'(i2s_sdata), 64'd0);
    chk("midrst_pulses", 64'({underrun, overflow}), 64'd0);
    do_reset();
    exp_q.push_back(16'h0000); exp_q.push_back(16'h0000);
    wait_until(200);
    chk("midrst_underrun", 64'(und_cnt), 64'd1);
    finish_test("midrst", 600);
    chk("midrst_sdata_quiet", 64'(sdata_seen), 64'd0);

    // Standalone FIFO boundaries through the interface
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      f_bus.push = 1'b1; f_bus.din = 16'(16'h0100 + i);
      @(negedge clk_50m);
    end
    f_bus.push = 1'b0;
    chk("fifo_full", 64'(f_bus.full), 64'd1);
    chk("fifo_count_full", 64'(f_bus.count), 64'(DEPTH));
    f_bus.push = 1'b1; f_bus.pop = 1'b1; f_bus.din = 16'h0200;
    @(negedge clk_50m);
    f_bus.push = 1'b0; f_bus.pop = 1'b0;
    chk("fifo_count_pushpop", 64'(f_bus.count), 64'(DEPTH));
    for (int i = 1; i <= DEPTH; i++) begin
      chk("fifo_order", 64'(f_bus.dout), (i < DEPTH) ? 64'(16'h0100 + i) : 64'h0200);
      f_bus.pop = 1'b1;
      @(negedge clk_50m);
      f_bus.pop = 1'b0;
    end
    chk("fifo_empty", 64'(f_bus.empty), 64'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
